mio_bus_arbiter: RTL and testbench
==================================

Name: mio_bus_arbiter

Overview:
- Shares the single memory/IO bus between two requesters:
  - m0, the multi-cycle CPU controller (MemRead/MemWrite + MIO_ready style handshake).
  - m1, a secondary master (DMA/display fetch).
- Grants the bus round-robin and drives the memory for a fixed latency.
- Returns read data plus a one-cycle ready pulse to the owning master.
- Sits between the CPU datapath/controller, the peripheral master and the RAM/MIO decoder.

Parameters:
- MEM_LAT, 1, number of cycles mem_en is held per access; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk in 1: system clock, all logic on posedge.
- reset in 1: synchronous, active-high reset.
- m0_rd in 1: CPU read request; held until m0_ready.
- m0_wr in 1: CPU write request; held until m0_ready.
- m0_addr in AW: CPU address.
- m0_wdata in DW: CPU write data.
- m0_rdata out DW: read data returned to the CPU.
- m0_ready out 1: one-cycle completion pulse to the CPU (feeds MIO_ready).
- m1_rd in 1: secondary master read request.
- m1_wr in 1: secondary master write request.
- m1_addr in AW: secondary master address.
- m1_wdata in DW: secondary master write data.
- m1_rdata out DW: read data returned to the secondary master.
- m1_ready out 1: one-cycle completion pulse to the secondary master.
- mem_en out 1: memory access strobe.
- mem_we out 1: memory write enable, qualified by mem_en.
- mem_addr out AW: memory address.
- mem_wdata out DW: memory write data.
- mem_rdata in DW: memory read data, valid during the last mem_en cycle.
- owner out 1: current or last granted master, 0 = CPU.
- busy out 1: high in ACCESS and DONE.

Behaviour:
- Clock and reset: one clock domain. Synchronous, active-high reset.
- Reset values: state = IDLE, all of the following = 0:
  - mem_en, mem_we, mem_addr, mem_wdata
  - m0_ready, m1_ready, m0_rdata, m1_rdata
  - busy, owner
  - priority pointer (favours m0)
- Request definition: reqX = mX_rd | mX_wr. If both rd and wr are asserted, the access is a write.
- State IDLE:
  - On a posedge with req0 | req1, pick the winner:
    - Only one requesting: that master wins.
    - Both requesting: the master named by the priority pointer wins.
  - Latch the winner's addr, wdata and write flag into mem_* and set owner. Load the counter with MEM_LAT-1. Go to ACCESS.
  - With no request, stay in IDLE with mem_en = 0.
- State ACCESS:
  - mem_en = 1. mem_we = latched write flag. mem_addr and mem_wdata stay stable.
  - Counter decrements each cycle.
  - When the counter is 0: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), drop mem_en/mem_we, pulse the owner's ready, go to DONE.
- State DONE:
  - The owner's ready is high for exactly this one cycle.
  - The priority pointer is set to the non-owner.
  - Next state is IDLE unconditionally. No new grant is made in DONE, so a master that lowers its request on the ready edge is never re-issued.
- Latency: request first seen at edge T → mem_en high for cycles T+1..T+MEM_LAT → ready high in cycle T+MEM_LAT+1. Minimum request-to-ready is 2 cycles (MEM_LAT = 1).
- Back-to-back: a re-asserted request is granted at the first IDLE edge after DONE. Throughput is one access per MEM_LAT+2 cycles.
- Request dropped mid-access: the access still completes and ready still pulses. Inputs are ignored outside IDLE.
- Non-owner ready: stays 0 throughout. Its rdata holds its last value.
- Reset mid-access: the access is aborted at the reset edge. mem_en goes low the next cycle, no ready is issued, and the pointer returns to m0.
- rdata registers: change only on a completed read by that master.

Test Plan:
- Single CPU read, MEM_LAT=1, m0_addr=0x10, mem_rdata=0xDEADBEEF → mem_en high 1 cycle at addr 0x10, we=0; m0_ready pulses 2 cycles after request; m0_rdata=0xDEADBEEF; m1_ready stays 0.
- Simultaneous requests after reset, MEM_LAT=2, m0 write 0x1234 to 0x20, m1 read 0x40 → m0 served first (mem_en 2 cycles, we=1, wdata=0x1234); m1 granted next IDLE; owner 0 then 1.
- Both masters requesting continuously for 4 accesses → grants alternate m0,m1,m0,m1; each ready is a single-cycle pulse; no double issue.
- m0_rd and m0_wr both high → mem_we=1 (write wins); m0_rdata unchanged.
- reset asserted in the second ACCESS cycle, MEM_LAT=3 → no ready pulse; mem_en=0 next cycle; the following simultaneous request goes to m0.
- m1 drops its request mid-access → mem_en still lasts MEM_LAT cycles; m1_ready still pulses once; arbiter returns to IDLE.

Source files
------------

// File: rtl/mio_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory/IO bus.
// Holds the memory strobe for MEM_LAT cycles, then pulses the owner's ready.
module mio_bus_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_rd,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  input  logic          m1_rd,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          prio_q, prio_d;

  logic          req0;
  logic          req1;
  logic          pick1;

  assign req0  = m0_rd | m0_wr;
  assign req1  = m1_rd | m1_wr;
  // prio_q names the master that wins a tie
  assign pick1 = req1 & (~req0 | prio_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m0_ready_d  = 1'b0;
    m1_ready_d  = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    prio_d      = prio_q;

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d     = pick1;
          mem_addr_d  = pick1 ? m1_addr : m0_addr;
          mem_wdata_d = pick1 ? m1_wdata : m0_wdata;
          mem_we_d    = pick1 ? m1_wr : m0_wr;
          mem_en_d    = 1'b1;
          cnt_d       = LAT_M1;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!mem_we_q) begin
            if (owner_q) m1_rdata_d = mem_rdata;
            else         m0_rdata_d = mem_rdata;
          end
          m0_ready_d = ~owner_q;
          m1_ready_d = owner_q;
          mem_en_d   = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        prio_d  = ~owner_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_ready_q  <= m0_ready_d;
      m1_ready_q  <= m1_ready_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      prio_q      <= prio_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter with MEM_LAT = 1, 2 and 3 instances.
// Inputs are shared; sel picks which instance is being observed.
module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] mem_rdata;

  logic [2:0]       en_v, we_v, rdy0_v, rdy1_v, own_v, busy_v;
  logic [2:0][31:0] addr_v, wd_v, rd0_v, rd1_v;

  logic [1:0]  sel;
  logic        en, we_o, rdy0, rdy1, own, bsy;
  logic [31:0] maddr, mwd, rd0, rd1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mio_bus_arbiter #(
      .MEM_LAT(g + 1),
      .AW(32),
      .DW(32)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .m0_rd    (m0_rd),
      .m0_wr    (m0_wr),
      .m0_addr  (m0_addr),
      .m0_wdata (m0_wdata),
      .m0_rdata (rd0_v[g]),
      .m0_ready (rdy0_v[g]),
      .m1_rd    (m1_rd),
      .m1_wr    (m1_wr),
      .m1_addr  (m1_addr),
      .m1_wdata (m1_wdata),
      .m1_rdata (rd1_v[g]),
      .m1_ready (rdy1_v[g]),
      .mem_en   (en_v[g]),
      .mem_we   (we_v[g]),
      .mem_addr (addr_v[g]),
      .mem_wdata(wd_v[g]),
      .mem_rdata(mem_rdata),
      .owner    (own_v[g]),
      .busy     (busy_v[g])
    );
  end

  always_comb begin
    en    = en_v[sel];
    we_o  = we_v[sel];
    rdy0  = rdy0_v[sel];
    rdy1  = rdy1_v[sel];
    own   = own_v[sel];
    bsy   = busy_v[sel];
    maddr = addr_v[sel];
    mwd   = wd_v[sel];
    rd0   = rd0_v[sel];
    rd1   = rd1_v[sel];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr_req();
    m0_rd = 1'b0;
    m0_wr = 1'b0;
    m1_rd = 1'b0;
    m1_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_req();
    step();
    step();
    reset = 1'b0;
  endtask

  // Grant edge, MEM_LAT strobe cycles, then the ready cycle.
  task automatic access(input bit exp_own, input bit exp_we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int drop_at);
    int lat;
    lat = int'(sel) + 1;
    for (int i = 0; i < lat; i++) begin
      step();
      chk("acc_en", 32'(en), 32'd1);
      chk("acc_we", 32'(we_o), 32'(exp_we));
      chk("acc_addr", maddr, a);
      chk("acc_wdata", mwd, wd);
      chk("acc_owner", 32'(own), 32'(exp_own));
      chk("acc_busy", 32'(bsy), 32'd1);
      chk("acc_rdy0", 32'(rdy0), 32'd0);
      chk("acc_rdy1", 32'(rdy1), 32'd0);
      if (i == drop_at) clr_req();
    end
    step();
    chk("done_en", 32'(en), 32'd0);
    chk("done_we", 32'(we_o), 32'd0);
    chk("done_rdy0", 32'(rdy0), 32'(!exp_own));
    chk("done_rdy1", 32'(rdy1), 32'(exp_own));
    chk("done_busy", 32'(bsy), 32'd1);
  endtask

  task automatic idle_chk();
    step();
    chk("idle_en", 32'(en), 32'd0);
    chk("idle_rdy0", 32'(rdy0), 32'd0);
    chk("idle_rdy1", 32'(rdy1), 32'd0);
    chk("idle_busy", 32'(bsy), 32'd0);
  endtask

  initial begin
    sel       = 2'd0;
    m0_addr   = '0;
    m0_wdata  = '0;
    m1_addr   = '0;
    m1_wdata  = '0;
    mem_rdata = '0;
    do_reset();

    chk("rst_en", 32'(en), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_addr", maddr, 32'd0);
    chk("rst_owner", 32'(own), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_rdy0", 32'(rdy0), 32'd0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);

    // single CPU read, MEM_LAT=1
    m0_rd     = 1'b1;
    m0_addr   = 32'h10;
    mem_rdata = 32'hDEADBEEF;
    access(1'b0, 1'b0, 32'h10, 32'h0, -1);
    chk("t1_rd0", rd0, 32'hDEADBEEF);
    chk("t1_rd1", rd1, 32'h0);
    m0_rd = 1'b0;
    idle_chk();

    // simultaneous after reset, MEM_LAT=2
    sel = 2'd1;
    do_reset();
    m0_wr     = 1'b1;
    m0_addr   = 32'h20;
    m0_wdata  = 32'h1234;
    m1_rd     = 1'b1;
    m1_addr   = 32'h40;
    m1_wdata  = 32'h5555;
    mem_rdata = 32'hCAFE0001;
    access(1'b0, 1'b1, 32'h20, 32'h1234, -1);
    chk("t2_rd0_keep", rd0, 32'h0);
    m0_wr = 1'b0;
    idle_chk();
    chk("t2_owner_idle", 32'(own), 32'd0);
    access(1'b1, 1'b0, 32'h40, 32'h5555, -1);
    chk("t2_rd1", rd1, 32'hCAFE0001);
    chk("t2_rd0", rd0, 32'h0);
    m1_rd = 1'b0;
    idle_chk();

    // continuous requests alternate m0,m1,m0,m1
    m0_rd    = 1'b1;
    m0_addr  = 32'h100;
    m0_wdata = 32'h0;
    m1_rd    = 1'b1;
    m1_addr  = 32'h200;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'hA0000000 + 32'(i);
      if (i % 2 == 0) begin
        access(1'b0, 1'b0, 32'h100, 32'h0, -1);
        chk("t3_rd0", rd0, 32'hA0000000 + 32'(i));
      end else begin
        access(1'b1, 1'b0, 32'h200, 32'h5555, -1);
        chk("t3_rd1", rd1, 32'hA0000000 + 32'(i));
      end
      if (i == 3) clr_req();
      idle_chk();
    end

    // rd and wr together is a write, rdata untouched
    sel = 2'd0;
    do_reset();
    m0_rd     = 1'b1;
    m0_addr   = 32'h30;
    m0_wdata  = 32'h0;
    mem_rdata = 32'h11112222;
    access(1'b0, 1'b0, 32'h30, 32'h0, -1);
    chk("t4_rd0_load", rd0, 32'h11112222);
    m0_wr     = 1'b1;
    m0_wdata  = 32'h77;
    mem_rdata = 32'h99;
    idle_chk();
    access(1'b0, 1'b1, 32'h30, 32'h77, -1);
    chk("t4_rd0_keep", rd0, 32'h11112222);
    clr_req();
    idle_chk();

    // reset in second ACCESS cycle, MEM_LAT=3
    sel = 2'd2;
    do_reset();
    m0_rd     = 1'b1;
    m0_addr   = 32'h50;
    m0_wdata  = 32'h0;
    mem_rdata = 32'h55;
    access(1'b0, 1'b0, 32'h50, 32'h0, -1);
    m0_rd = 1'b0;
    idle_chk();
    chk("t5_rd0", rd0, 32'h55);
    m0_rd   = 1'b1;
    m0_addr = 32'h60;
    step();
    chk("t5_acc1_en", 32'(en), 32'd1);
    step();
    chk("t5_acc2_en", 32'(en), 32'd1);
    reset = 1'b1;
    step();
    chk("t5_rst_en", 32'(en), 32'd0);
    chk("t5_rst_rdy0", 32'(rdy0), 32'd0);
    chk("t5_rst_busy", 32'(bsy), 32'd0);
    chk("t5_rst_owner", 32'(own), 32'd0);
    reset     = 1'b0;
    m1_rd     = 1'b1;
    m1_addr   = 32'h70;
    m1_wdata  = 32'h0;
    mem_rdata = 32'h66;
    access(1'b0, 1'b0, 32'h60, 32'h0, -1);
    chk("t5_rd0_after", rd0, 32'h66);
    m0_rd = 1'b0;

    // m1 drops its request mid-access
    mem_rdata = 32'h77777777;
    idle_chk();
    access(1'b1, 1'b0, 32'h70, 32'h0, 0);
    chk("t6_rd1", rd1, 32'h77777777);
    idle_chk();
    idle_chk();
    chk("t6_owner", 32'(own), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
